// File: rtl/maquina_pkg.sv
// rtl/maquina_pkg.sv - shared state encoding, error codes and monitor mode for the coffee machine
// Purpose: single source of truth for the controller state encoding (also used by
//          maquina_maluca), the 3-bit monitor error codes and the monitor mode FSM.
// Ports:   none (package).
package maquina_pkg;

  localparam logic [3:0] ST_IDLE                = 4'd1;
  localparam logic [3:0] ST_LIGAR_MAQUINA       = 4'd2;
  localparam logic [3:0] ST_VERIFICAR_AGUA      = 4'd3;
  localparam logic [3:0] ST_ENCHER_RESERVATORIO = 4'd4;
  localparam logic [3:0] ST_MOER_CAFE           = 4'd5;
  localparam logic [3:0] ST_COLOCAR_NO_FILTRO   = 4'd6;
  localparam logic [3:0] ST_PASSAR_AGITADOR     = 4'd7;
  localparam logic [3:0] ST_TAMPEAR             = 4'd8;
  localparam logic [3:0] ST_REALIZAR_EXTRACAO   = 4'd9;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL  = 3'd1;
  localparam logic [2:0] ERR_ENCODING = 3'd2;
  localparam logic [2:0] ERR_REFILL   = 3'd3;
  localparam logic [2:0] ERR_WATCHDOG = 3'd4;
  localparam logic [2:0] ERR_NO_START = 3'd5;

  typedef enum logic [1:0] {
    MON_IDLE   = 2'd0,
    MON_ACTIVE = 2'd1,
    MON_ERROR  = 2'd2
  } mon_mode_t;

  function automatic logic state_valid(input logic [3:0] s);
    return (s >= ST_IDLE) && (s <= ST_REALIZAR_EXTRACAO);
  endfunction

  // Structural legality only; the start qualification of IDLE->LIGAR is checked separately.
  function automatic logic step_legal(input logic [3:0] prev, input logic [3:0] cur);
    logic ok;
    ok = 1'b0;
    if (prev == cur) begin
      ok = 1'b1;
    end else begin
      case (prev)
        ST_IDLE:                ok = (cur == ST_LIGAR_MAQUINA);
        ST_LIGAR_MAQUINA:       ok = (cur == ST_VERIFICAR_AGUA);
        ST_VERIFICAR_AGUA:      ok = (cur == ST_ENCHER_RESERVATORIO) || (cur == ST_MOER_CAFE);
        ST_ENCHER_RESERVATORIO: ok = (cur == ST_VERIFICAR_AGUA);
        ST_MOER_CAFE:           ok = (cur == ST_COLOCAR_NO_FILTRO);
        ST_COLOCAR_NO_FILTRO:   ok = (cur == ST_PASSAR_AGITADOR);
        ST_PASSAR_AGITADOR:     ok = (cur == ST_TAMPEAR);
        ST_TAMPEAR:             ok = (cur == ST_REALIZAR_EXTRACAO);
        ST_REALIZAR_EXTRACAO:   ok = (cur == ST_IDLE);
        default:                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/maquina_wdog.sv
// rtl/maquina_wdog.sv - dwell counter flagging a non-IDLE state held too long
// Purpose: counts consecutive samples spent in the same non-IDLE state; timeout is
//          high on the sample whose dwell count reaches WDOG_MAX+1.
// Ports:   clk, rst (sync active-high), state (current sample), prev_state/prev_valid
//          (previous sample and whether it exists), timeout (combinational, same sample).
module maquina_wdog
  import maquina_pkg::*;
#(
  parameter int WDOG_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic [3:0] prev_state,
  input  logic       prev_valid,
  output logic       timeout
);

  localparam int LIMIT = WDOG_MAX + 1;
  localparam int DW    = $clog2(LIMIT + 1);

  logic [DW-1:0] dwell;
  logic [DW-1:0] dwell_next;

  // The count includes the current sample, so entering a state starts at 1.
  always_comb begin
    dwell_next = dwell;
    if (state == ST_IDLE) begin
      dwell_next = '0;
    end else if (!prev_valid || (state != prev_state)) begin
      dwell_next = DW'(1);
    end else if (dwell != DW'(LIMIT)) begin
      dwell_next = dwell + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell <= '0;
    end else begin
      dwell <= dwell_next;
    end
  end

  assign timeout = (dwell_next == DW'(LIMIT));

endmodule

// File: rtl/maquina_monitor.sv
// rtl/maquina_monitor.sv - passive checker of the coffee machine state/start stream
// Purpose: validates each sampled controller transition, counts brews and refill loops,
//          and latches the first violation as a sticky error code.
// Optional: MAQUINA_MONITOR_WDOG_EN builds the maquina_wdog dwell watchdog (code 4).
// Ports:   clk, rst (sync active-high), start (controller start request),
//          state (controller state), busy (last sample not IDLE), done (brew-complete pulse),
//          err/err_code (sticky first violation), brew_count (saturating),
//          last_refills (refill loops of the latest completed brew).
module maquina_monitor
  import maquina_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int MAX_REFILLS = 4,
  parameter int WDOG_MAX    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       state,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] brew_count,
  output logic [3:0]       last_refills
);

  logic [3:0] prev_state;
  logic       start_q;
  logic       prev_valid;
  logic [3:0] refill_cnt;
  mon_mode_t  mode;
  mon_mode_t  mode_next;

  logic       wdog_timeout;
  logic       idle_to_ligar;
  logic       refill_step;
  logic       brew_end;
  logic [4:0] refill_inc;
  logic [2:0] viol_code;
  logic       viol;

`ifdef MAQUINA_MONITOR_WDOG_EN
  maquina_wdog #(
    .WDOG_MAX(WDOG_MAX)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .prev_state(prev_state),
    .prev_valid(prev_valid),
    .timeout   (wdog_timeout)
  );
`else
  // No dwell counter: the watchdog can never fire (WDOG_MAX is never negative).
  assign wdog_timeout = (WDOG_MAX < 0);
`endif

  // Violation detection; the if/else chain encodes the error-code priority.
  always_comb begin
    idle_to_ligar = 1'b0;
    refill_step   = 1'b0;
    brew_end      = 1'b0;
    viol_code     = ERR_NONE;
    refill_inc    = {1'b0, refill_cnt} + 5'd1;

    if (prev_valid) begin
      idle_to_ligar = (prev_state == ST_IDLE) && (state == ST_LIGAR_MAQUINA);
      refill_step   = (prev_state == ST_VERIFICAR_AGUA) && (state == ST_ENCHER_RESERVATORIO);
      brew_end      = (prev_state == ST_REALIZAR_EXTRACAO) && (state == ST_IDLE);
    end

    if (!state_valid(state)) begin
      viol_code = ERR_ENCODING;
    end else if (idle_to_ligar && !start_q) begin
      viol_code = ERR_NO_START;
    end else if (prev_valid && !step_legal(prev_state, state)) begin
      viol_code = ERR_ILLEGAL;
    end else if (refill_step && (refill_inc > 5'(MAX_REFILLS))) begin
      viol_code = ERR_REFILL;
    end else if (wdog_timeout) begin
      viol_code = ERR_WATCHDOG;
    end

    viol = (viol_code != ERR_NONE);
  end

  always_comb begin
    mode_next = mode;
    case (mode)
      MON_IDLE: begin
        if (viol)               mode_next = MON_ERROR;
        else if (idle_to_ligar) mode_next = MON_ACTIVE;
      end
      MON_ACTIVE: begin
        if (viol)          mode_next = MON_ERROR;
        else if (brew_end) mode_next = MON_IDLE;
      end
      MON_ERROR: mode_next = MON_ERROR;
      default:   mode_next = MON_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= MON_IDLE;
    end else begin
      mode <= mode_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state   <= ST_IDLE;
      start_q      <= 1'b0;
      prev_valid   <= 1'b0;
      refill_cnt   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      brew_count   <= '0;
      last_refills <= '0;
    end else begin
      prev_state <= state;
      start_q    <= start;
      prev_valid <= 1'b1;
      busy       <= (state != ST_IDLE);
      done       <= 1'b0;

      if (idle_to_ligar) begin
        refill_cnt <= '0;
      end else if (refill_step && (viol_code != ERR_REFILL)) begin
        refill_cnt <= refill_inc[3:0];
      end

      // Once in MON_ERROR the first code is kept and brew bookkeeping freezes.
      if (mode != MON_ERROR) begin
        if (viol) begin
          err      <= 1'b1;
          err_code <= viol_code;
        end else if (brew_end) begin
          done         <= 1'b1;
          last_refills <= refill_cnt;
          if (brew_count != {CNT_W{1'b1}}) begin
            brew_count <= brew_count + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_maquina_monitor.sv
// tb/tb_maquina_monitor.sv - scoreboard bench for maquina_monitor with directed state streams
module tb_maquina_monitor;

  localparam int MAXR = 2;
  localparam int WDOG = 8;
`ifdef MAQUINA_MONITOR_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] code;
    logic [7:0] cnt;
    logic [3:0] lr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] state = 4'd1;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] err_code;
  logic [7:0] brew_count;
  logic [3:0] last_refills;

  exp_t exp_q[$];
  int   id_q[$];
  int   step_no = 0;
  int   checks  = 0;
  int   errors  = 0;

  maquina_monitor #(
    .CNT_W      (8),
    .MAX_REFILLS(MAXR),
    .WDOG_MAX   (WDOG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .state       (state),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .brew_count  (brew_count),
    .last_refills(last_refills)
  );

  always #5 clk = ~clk;

  // Drive one sample, then queue the outputs expected just after that edge.
  task automatic step(input int r, input int s, input int st,
                      input int b, input int d, input int e, input int c,
                      input int n, input int lr);
    exp_t x;
    rst   = r[0];
    start = s[0];
    state = st[3:0];
    @(posedge clk);
    x.busy = b[0];
    x.done = d[0];
    x.err  = e[0];
    x.code = c[2:0];
    x.cnt  = n[7:0];
    x.lr   = lr[3:0];
    exp_q.push_back(x);
    id_q.push_back(step_no);
    step_no++;
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int we;
    int wc;

    fork
      forever begin
        exp_t x;
        exp_t g;
        int   id;
        @(negedge clk);
        if (exp_q.size() > 0) begin
          x  = exp_q.pop_front();
          id = id_q.pop_front();
          g.busy = busy;
          g.done = done;
          g.err  = err;
          g.code = err_code;
          g.cnt  = brew_count;
          g.lr   = last_refills;
          checks++;
          if (g !== x) begin
            errors++;
            $display("FAIL step%0d got busy=%0b done=%0b err=%0b code=%0d cnt=%0d lr=%0d required busy=%0b done=%0b err=%0b code=%0d cnt=%0d lr=%0d",
                     id, g.busy, g.done, g.err, g.code, g.cnt, g.lr,
                     x.busy, x.done, x.err, x.code, x.cnt, x.lr);
          end
        end
      end
    join_none

    // Nominal brew with one refill loop.
    do_reset();
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 2, 1, 0, 0, 0, 0, 0);
    step(0, 0, 3, 1, 0, 0, 0, 0, 0);
    step(0, 0, 4, 1, 0, 0, 0, 0, 0);
    step(0, 0, 3, 1, 0, 0, 0, 0, 0);
    step(0, 0, 5, 1, 0, 0, 0, 0, 0);
    step(0, 0, 6, 1, 0, 0, 0, 0, 0);
    step(0, 0, 7, 1, 0, 0, 0, 0, 0);
    step(0, 0, 8, 1, 0, 0, 0, 0, 0);
    step(0, 0, 9, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0, 0, 0, 1, 1);

    // Reset in the middle of a second brew clears the counters too.
    step(0, 1, 1, 0, 0, 0, 0, 1, 1);
    step(0, 0, 2, 1, 0, 0, 0, 1, 1);
    step(0, 0, 3, 1, 0, 0, 0, 1, 1);
    step(1, 0, 3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Skipped 5->7: illegal transition, later completion is ignored, code is sticky.
    do_reset();
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 2, 1, 0, 0, 0, 0, 0);
    step(0, 0, 3, 1, 0, 0, 0, 0, 0);
    step(0, 0, 5, 1, 0, 0, 0, 0, 0);
    step(0, 0, 7, 1, 0, 1, 1, 0, 0);
    step(0, 0, 8, 1, 0, 1, 1, 0, 0);
    step(0, 0, 9, 1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 1, 1, 0, 0);
    step(0, 0, 12, 1, 0, 1, 1, 0, 0);

    // Invalid encoding on the very first sample after reset.
    step(1, 0, 12, 0, 0, 0, 0, 0, 0);
    step(0, 0, 12, 1, 0, 1, 2, 0, 0);
    step(0, 0, 1, 0, 0, 1, 2, 0, 0);

    // IDLE->LIGAR without start on the previous edge.
    do_reset();
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 2, 1, 0, 1, 5, 0, 0);

    // Third refill loop exceeds MAX_REFILLS=2.
    do_reset();
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 2, 1, 0, 0, 0, 0, 0);
    step(0, 0, 3, 1, 0, 0, 0, 0, 0);
    step(0, 0, 4, 1, 0, 0, 0, 0, 0);
    step(0, 0, 3, 1, 0, 0, 0, 0, 0);
    step(0, 0, 4, 1, 0, 0, 0, 0, 0);
    step(0, 0, 3, 1, 0, 0, 0, 0, 0);
    step(0, 0, 4, 1, 0, 1, 3, 0, 0);

    // Hold 6 for nine samples: watchdog trips on the ninth only when built.
    do_reset();
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 2, 1, 0, 0, 0, 0, 0);
    step(0, 0, 3, 1, 0, 0, 0, 0, 0);
    step(0, 0, 5, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      we = (WD && (i == 9)) ? 1 : 0;
      wc = (we != 0) ? 4 : 0;
      step(0, 0, 6, 1, 0, we, wc, 0, 0);
    end
    we = WD ? 1 : 0;
    wc = WD ? 4 : 0;
    step(0, 0, 7, 1, 0, we, wc, 0, 0);
    step(0, 0, 8, 1, 0, we, wc, 0, 0);
    step(0, 0, 9, 1, 0, we, wc, 0, 0);
    step(0, 0, 1, 0, WD ? 0 : 1, we, wc, WD ? 0 : 1, 0);
    step(0, 0, 1, 0, 0, we, wc, WD ? 0 : 1, 0);

    // Reset clears a latched error.
    do_reset();
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(posedge clk);
    end
    #6;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
